// File: rtl/pipeline_sink.sv
// pipeline_sink: receiving end of the global-stall pipeline pair.
// Two producer streams land in small per-stream circular FIFOs, which are
// drained through one shared output port at a fixed throttled rate with
// round-robin arbitration. A global stall is raised when either FIFO nears
// full, and every drained word is checked for increment-by-one ordering.
module pipeline_sink #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int STALL_THRESH = DEPTH - 2,
    parameter int DRAIN_PERIOD = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data_1,
    input  logic                  in_valid_1,
    input  logic [DATA_WIDTH-1:0] in_data_2,
    input  logic                  in_valid_2,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] drain_data,
    output logic                  drain_valid,
    output logic                  drain_sel,
    output logic [15:0]           count_1,
    output logic [15:0]           count_2,
    output logic                  err_1,
    output logic                  err_2,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int TMR_W = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_THR  = OCC_W'(STALL_THRESH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_PERIOD - 1);

    // Streams gathered into indexable vectors: index 0 = stream 1, 1 = stream 2.
    logic [1:0][DATA_WIDTH-1:0] in_data_a;
    logic [1:0]                 in_valid_a;
    logic [1:0][DATA_WIDTH-1:0] head_data;
    logic [1:0]                 not_empty;
    logic [1:0]                 near_full;
    logic [1:0]                 drop;
    logic [1:0]                 rd_en;
    logic [1:0][15:0]           count_a;
    logic [1:0]                 err_a;

    assign in_data_a  = {in_data_2, in_data_1};
    assign in_valid_a = {in_valid_2, in_valid_1};

    // Shared drain timer, arbiter and output registers.
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  rr_q, rr_d;
    logic                  drain_go;
    logic                  pick;
    logic                  drain_valid_q;
    logic [DATA_WIDTH-1:0] drain_data_q;
    logic                  drain_sel_q;
    logic                  overflow_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stream
            logic [DATA_WIDTH-1:0] mem_q [DEPTH];
            logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
            logic [OCC_W-1:0]      occ_q, occ_d;
            logic                  wr_en;
            logic                  seen_q, seen_d;
            logic [DATA_WIDTH-1:0] exp_q, exp_d;
            logic                  err_q, err_d;
            logic [15:0]           cnt_q, cnt_d;

            // Fullness is judged on the pre-edge occupancy, so a same-cycle
            // read never rescues a word arriving at a full FIFO.
            assign wr_en    = reset && in_valid_a[gi] && (occ_q != OCC_FULL);
            assign drop[gi] = reset && in_valid_a[gi] && (occ_q == OCC_FULL);

            assign head_data[gi] = mem_q[rd_ptr_q];
            assign not_empty[gi] = (occ_q != '0);
            assign near_full[gi] = (occ_q >= OCC_THR);
            assign count_a[gi]   = cnt_q;
            assign err_a[gi]     = err_q;

            // Storage array; contents need no reset since pointers define validity.
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem_q[wr_ptr_q] <= in_data_a[gi];
                end
            end

            // Next-state for pointers, occupancy, sequence checker and drain count.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                occ_d    = occ_q;
                seen_d   = seen_q;
                exp_d    = exp_q;
                err_d    = err_q;
                cnt_d    = cnt_q;

                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                if (rd_en[gi]) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end

                case ({wr_en, rd_en[gi]})
                    2'b10:   occ_d = occ_q + OCC_W'(1);
                    2'b01:   occ_d = occ_q - OCC_W'(1);
                    default: occ_d = occ_q;
                endcase

                // The first drained word only seeds the expectation; later
                // words are compared, and the expectation always follows the
                // actual word so one bad word is flagged exactly once.
                if (rd_en[gi]) begin
                    seen_d = 1'b1;
                    exp_d  = head_data[gi] + DATA_WIDTH'(1);
                    if (seen_q && (head_data[gi] != exp_q)) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            // Per-stream state registers with synchronous active-low reset.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    occ_q    <= '0;
                    seen_q   <= 1'b0;
                    exp_q    <= '0;
                    err_q    <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    occ_q    <= occ_d;
                    seen_q   <= seen_d;
                    exp_q    <= exp_d;
                    err_q    <= err_d;
                    cnt_q    <= cnt_d;
                end
            end
        end
    endgenerate

    // Drain timer and round-robin arbitration between the two FIFO heads.
    always_comb begin
        timer_d  = timer_q;
        rr_d     = rr_q;
        drain_go = 1'b0;
        pick     = rr_q;
        rd_en    = '0;

        if (timer_q == TMR_LAST) begin
            timer_d = '0;
            if (not_empty[rr_q]) begin
                drain_go = 1'b1;
                pick     = rr_q;
            end else if (not_empty[~rr_q]) begin
                drain_go = 1'b1;
                pick     = ~rr_q;
            end
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end

        if (drain_go) begin
            rd_en[pick] = 1'b1;
            rr_d        = ~pick;
        end
    end

    // Shared registers: timer, arbiter pointer, drain port and overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer_q       <= '0;
            rr_q          <= 1'b0;
            drain_valid_q <= 1'b0;
            drain_data_q  <= '0;
            drain_sel_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            rr_q          <= rr_d;
            drain_valid_q <= drain_go;
            if (drain_go) begin
                drain_data_q <= head_data[pick];
                drain_sel_q  <= pick;
            end
            if (|drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Stall comes straight from the registered occupancies, no extra flop.
    assign stall       = |near_full;
    assign drain_valid = drain_valid_q;
    assign drain_data  = drain_data_q;
    assign drain_sel   = drain_sel_q;
    assign count_1     = count_a[0];
    assign count_2     = count_a[1];
    assign err_1       = err_a[0];
    assign err_2       = err_a[1];
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pipeline_sink.sv
// Testbench for pipeline_sink: queue-based reference model, scoreboard of
// expected drains, and a negedge monitor comparing every output each cycle.
module tb_pipeline_sink;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int THR   = DEPTH - 2;
    localparam int P     = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data_1 = '0;
    logic          in_valid_1 = 1'b0;
    logic [DW-1:0] in_data_2 = '0;
    logic          in_valid_2 = 1'b0;
    logic          stall;
    logic [DW-1:0] drain_data;
    logic          drain_valid;
    logic          drain_sel;
    logic [15:0]   count_1;
    logic [15:0]   count_2;
    logic          err_1;
    logic          err_2;
    logic          overflow;

    always #5 clk = ~clk;

    pipeline_sink #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .STALL_THRESH(THR),
        .DRAIN_PERIOD(P)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data_1  (in_data_1),
        .in_valid_1 (in_valid_1),
        .in_data_2  (in_data_2),
        .in_valid_2 (in_valid_2),
        .stall      (stall),
        .drain_data (drain_data),
        .drain_valid(drain_valid),
        .drain_sel  (drain_sel),
        .count_1    (count_1),
        .count_2    (count_2),
        .err_1      (err_1),
        .err_2      (err_2),
        .overflow   (overflow)
    );

    // Reference model state: plain queues per stream plus bookkeeping.
    typedef struct {
        logic [DW-1:0] d;
        bit            s;
    } drain_t;

    logic [DW-1:0] mq [2][$];
    int            m_cycle;
    bit            m_rr;
    int            m_cnt [2];
    bit            m_err [2];
    bit            m_seen [2];
    logic [DW-1:0] m_exp [2];
    bit            m_ovf;
    drain_t        sb [$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_stall();
        return (mq[0].size() >= THR) || (mq[1].size() >= THR);
    endfunction

    task automatic model_reset();
        mq[0].delete();
        mq[1].delete();
        sb.delete();
        m_cycle = 0;
        m_rr    = 1'b0;
        m_ovf   = 1'b0;
        for (int s = 0; s < 2; s++) begin
            m_cnt[s]  = 0;
            m_err[s]  = 1'b0;
            m_seen[s] = 1'b0;
            m_exp[s]  = '0;
        end
    endtask

    // Advance the model by one clock edge using the pre-edge state.
    task automatic model_edge(input bit rst, input bit v1, input logic [DW-1:0] d1,
                              input bit v2, input logic [DW-1:0] d2);
        int pre [2];
        bit v [2];
        logic [DW-1:0] d [2];
        int take;
        logic [DW-1:0] w;
        drain_t e;
        if (!rst) begin
            model_reset();
            return;
        end
        v[0] = v1; v[1] = v2; d[0] = d1; d[1] = d2;
        pre[0] = mq[0].size();
        pre[1] = mq[1].size();
        take = -1;
        if ((m_cycle % P) == P - 1) begin
            if (pre[m_rr] > 0) take = m_rr;
            else if (pre[1 - m_rr] > 0) take = 1 - m_rr;
        end
        m_cycle++;
        if (take >= 0) begin
            w = mq[take].pop_front();
            e.d = w;
            e.s = take[0];
            sb.push_back(e);
            if (m_seen[take] && (w != m_exp[take])) m_err[take] = 1'b1;
            m_seen[take] = 1'b1;
            m_exp[take]  = w + 1;
            if (m_cnt[take] < 65535) m_cnt[take]++;
            m_rr = (take == 0);
        end
        for (int s = 0; s < 2; s++) begin
            if (v[s]) begin
                if (pre[s] < DEPTH) mq[s].push_back(d[s]);
                else m_ovf = 1'b1;
            end
        end
    endtask

    // One cycle of stimulus: drive just after the falling edge, update model.
    task automatic step(input bit rst, input bit v1, input logic [DW-1:0] d1,
                        input bit v2, input logic [DW-1:0] d2);
        @(negedge clk);
        #1;
        reset      = rst;
        in_valid_1 = v1;
        in_data_1  = d1;
        in_valid_2 = v2;
        in_data_2  = d2;
        model_edge(rst, v1, d1, v2, d2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    // Monitor: pop the scoreboard on every drain pulse and compare all outputs.
    always @(negedge clk) begin
        drain_t e;
        if (mon_en) begin
            if (drain_valid) begin
                if (sb.size() == 0) begin
                    chk("drain_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("drain_data", drain_data, e.d);
                    chk("drain_sel", drain_sel, e.s);
                    $display("drain sel=%0d data=%0h", drain_sel, drain_data);
                end
            end else if (sb.size() != 0) begin
                chk("drain_missing", 0, 1);
                void'(sb.pop_front());
            end
            chk("stall", stall, m_stall());
            chk("count_1", count_1, m_cnt[0]);
            chk("count_2", count_2, m_cnt[1]);
            chk("err_1", err_1, m_err[0]);
            chk("err_2", err_2, m_err[1]);
            chk("overflow", overflow, m_ovf);
        end
    end

    initial begin
        bit lag_stall;
        bit honour;
        int pv;
        logic [DW-1:0] seq1;
        logic [DW-1:0] seq2;
        bit v1;
        bit v2;
        model_reset();

        // Reset held with a valid word present: everything stays cleared.
        step(1'b0, 1'b1, 32'h55, 1'b0, '0);
        mon_en = 1'b1;
        step(1'b0, 1'b1, 32'h56, 1'b0, '0);
        idle(1);
        chk("reset_drain_valid", drain_valid, 0);
        chk("reset_drain_data", drain_data, 0);
        chk("reset_count_1", count_1, 0);
        chk("reset_stall", stall, 0);

        // Single stream: 1,2,3 drained in order from stream 1.
        step(1'b1, 1'b1, 1, 1'b0, '0);
        step(1'b1, 1'b1, 2, 1'b0, '0);
        step(1'b1, 1'b1, 3, 1'b0, '0);
        idle(12);
        chk("single_count_1", count_1, 3);
        chk("single_err_1", err_1, 0);

        // Round robin: 10,20,11,21 alternating sources.
        do_reset();
        step(1'b1, 1'b1, 10, 1'b1, 20);
        step(1'b1, 1'b1, 11, 1'b1, 21);
        idle(14);
        chk("rr_count_1", count_1, 2);
        chk("rr_count_2", count_2, 2);

        // Stall ignored: fill stream 1 every cycle, a word must be dropped.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 100 + i, 1'b0, '0);
        idle(20);
        chk("ovf_ignored", overflow, 1);

        // Stall honoured with one cycle of lag: no overflow.
        do_reset();
        lag_stall = 1'b0;
        seq1 = 200;
        for (int i = 0; i < 30; i++) begin
            v1 = !lag_stall;
            lag_stall = m_stall();
            step(1'b1, v1, seq1, 1'b0, '0);
            if (v1) seq1++;
        end
        idle(20);
        chk("ovf_honoured", overflow, 0);
        chk("honour_err_1", err_1, 0);

        // Sequence error on stream 2: 5,6,8,9 flags once.
        do_reset();
        step(1'b1, 1'b0, '0, 1'b1, 5);
        step(1'b1, 1'b0, '0, 1'b1, 6);
        step(1'b1, 1'b0, '0, 1'b1, 8);
        step(1'b1, 1'b0, '0, 1'b1, 9);
        idle(15);
        chk("seq_err_2", err_2, 1);
        chk("seq_count_2", count_2, 4);
        chk("seq_err_1", err_1, 0);

        // Wrap of the +1 expectation.
        do_reset();
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0, 1'b0, '0);
        idle(10);
        chk("wrap_err_1", err_1, 0);
        chk("wrap_count_1", count_1, 2);

        // Randomized traffic with occasional glitches and resets.
        do_reset();
        seq1 = $urandom;
        seq2 = $urandom;
        honour = 1'b1;
        pv = 50;
        lag_stall = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 250) == 0) begin
                honour = ($urandom_range(0, 3) != 0);
                pv = $urandom_range(10, 90);
            end
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                lag_stall = 1'b0;
            end else begin
                v1 = ($urandom_range(0, 99) < pv) && !(honour && lag_stall);
                v2 = ($urandom_range(0, 99) < pv) && !(honour && lag_stall);
                lag_stall = m_stall();
                step(1'b1, v1, seq1, v2, seq2);
                if (v1) seq1 = seq1 + (($urandom_range(0, 49) == 0) ? 2 : 1);
                if (v2) seq2 = seq2 + (($urandom_range(0, 49) == 0) ? 3 : 1);
            end
        end
        idle(30);
        chk("scoreboard_empty", sb.size(), 0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
